pll_dyn_ctrl: RTL and testbench
===============================

# pll_dyn_ctrl

Sequencer for the Gowin rPLL in dynamic-divider mode, clocked from the board reference clock. It holds the PLL in reset, programs the IDSEL/FBDSEL/ODSEL codes, and waits for lock with a timeout and bounded retries. It then requires lock to stay stable before releasing the core reset. It sits beside `clkgen`, driving the PLL's RESET and divider-select pins and gating the core reset. It also accepts runtime re-tune requests.

## Interface
- `RST_CYCLES`, 16: PLL RESET pulse width in cycles, minimum 2.
- `LOCK_TIMEOUT`, 65536: cycles allowed for lock per attempt.
- `SETTLE_CYCLES`, 1024: cycles of continuous lock required before release.
- `MAX_RETRY`, 3: PLL reset attempts per configuration before declaring failure.
- `DEF_IDSEL` / `DEF_FBDSEL` / `DEF_ODSEL`, 6'h3B / 6'h3D / 6'h30: codes applied after `i_rst`.
- `i_clk`, in, 1: reference clock; all logic is on its rising edge.
- `i_rst`, in, 1: reset, asynchronous, active-high.
- `i_pll_lock`, in, 1: raw PLL LOCK; synchronized internally with 2 flops.
- `i_req`, in, 1: re-tune request, level.
- `i_idsel` / `i_fbdsel` / `i_odsel`, in, 6 each: requested raw codes, valid while `i_req` is high.
- `o_ack`, out, 1: one-cycle pulse when a request is accepted.
- `o_busy`, out, 1: high in every state except RUN and FAIL.
- `o_pll_reset`, out, 1: drives the rPLL RESET pin.
- `o_idsel` / `o_fbdsel` / `o_odsel`, out, 6 each: registered codes driven to the PLL.
- `o_core_rst`, out, 1: active-high core reset.
- `o_locked`, out, 1: high only in RUN.
- `o_fail`, out, 1: high only in FAIL.
- `o_loss_cnt`, out, 8: lock-loss event count.

## Operation
- `lock_s` is the 2-flop-synchronized `i_pll_lock`.
- The block has a single timer and a retry counter.
- PLLRST:
  - `o_pll_reset`=1.
  - After `RST_CYCLES` cycles, go to WAITLOCK; the timer is cleared on entry.
- WAITLOCK:
  - `o_pll_reset`=0.
  - If `lock_s`=1, go to SETTLE.
  - If the timer reaches `LOCK_TIMEOUT`-1 without `lock_s`:
    - Increment the retry counter.
    - If retry count < `MAX_RETRY`, go to PLLRST; otherwise go to FAIL.
- SETTLE:
  - The timer counts cycles with `lock_s`=1.
  - If `lock_s`=0, return to WAITLOCK; the timer restarts and the retry count is unchanged.
  - After `SETTLE_CYCLES` consecutive cycles, go to RUN and clear the retry counter.
- RUN:
  - `o_core_rst`=0 and `o_locked`=1.
  - If `lock_s` falls: `o_core_rst`=1 on the next edge, go to WAITLOCK, and count one loss event.
- FAIL:
  - `o_fail`=1, `o_core_rst`=1, `o_pll_reset`=0.
  - The state is held until a request arrives.
- Request acceptance:
  - A request is accepted only in RUN or FAIL, on a cycle with `i_req`=1.
  - On acceptance: latch `i_*sel` into `o_*sel`, pulse `o_ack`, clear retries, set `o_core_rst`=1, go to PLLRST.
  - In any other state `i_req` is ignored; the requester holds `i_req` until it sees `o_ack`.
  - The requester must drop `i_req` on the cycle after `o_ack`. If `i_req` is still high in RUN, a second request is accepted.
- Simultaneous request and lock loss in RUN: the request wins. No loss event is counted.
- `o_core_rst`=1 in every state except RUN.
- The timer is sized `$clog2` of the largest count parameter. The retry counter is `$clog2(MAX_RETRY+1)` bits.

## Timing
- Reset values:
  - State PLLRST, timer 0, retries 0, sync flops 0.
  - `o_pll_reset`=1, `o_core_rst`=1, `o_busy`=1.
  - `o_locked`=0, `o_fail`=0, `o_ack`=0, `o_loss_cnt`=0.
  - `o_*sel` = `DEF_*`.
- `i_rst` asserted mid-operation returns everything to the reset values immediately (asynchronous) and discards the latched request codes.
- Lock acquisition latency:
  - `i_pll_lock` rises before edge n.
  - `lock_s`=1 after edge n+1.
  - `o_core_rst` falls after edge n+1+`SETTLE_CYCLES`.
- Lock loss in RUN: `o_core_rst` rises 3 edges after `i_pll_lock` falls (2 sync flops plus 1 registered output).
- All outputs are registered. `o_ack` coincides with the first PLLRST cycle.
- Applying the codes: `o_*sel` change on the same edge that `o_pll_reset` rises, so the PLL samples the codes while held in reset.

## Configuration
- Macro: `PLL_DYN_CTRL_LOSS_CNT_EN`.
- Defined: `o_loss_cnt` is an 8-bit counter that increments once per RUN→WAITLOCK lock-loss transition and saturates at 255. It is cleared only by `i_rst`.
- Undefined: `o_loss_cnt` is tied to 0 and no counter logic is synthesized.

## Test plan
All tests use `RST_CYCLES`=4, `LOCK_TIMEOUT`=32, `SETTLE_CYCLES`=8, `MAX_RETRY`=2.
- Power-up, with lock tied to 1 after reset:
  - `o_pll_reset`=1 for 4 cycles.
  - `o_core_rst` falls exactly 2+8 edges after entering WAITLOCK.
  - `o_*sel` = defaults.
- Lock never asserts:
  - Two PLLRST pulses, each followed by a 32-cycle wait.
  - Then `o_fail`=1, `o_busy`=0, `o_core_rst`=1.
  - A request in FAIL with codes 01/02/03 pulses `o_ack` and restarts the sequence with those codes.
- Lock glitch during SETTLE (low 1 cycle at settle count 5): the settle count restarts and release occurs 8 cycles after the relock.
- Lock loss in RUN:
  - `o_core_rst` rises 3 edges after `i_pll_lock` falls.
  - With the macro defined, `o_loss_cnt` goes 0→1.
  - Repeated 300 times, it saturates at 255.
- Re-tune:
  - `i_req` in RUN with codes 0A/0B/0C gives one `o_ack` pulse; `o_*sel` update and `o_pll_reset` rises on the same edge.
  - `i_req` held during PLLRST produces no `o_ack` until RUN.
  - Request and lock drop on the same cycle: `o_ack`=1 and the loss count is unchanged.
- Asynchronous `i_rst` pulse mid-SETTLE after a re-tune: outputs return to the reset values without a clock edge, and `o_*sel` = defaults.

Source files
------------

// File: rtl/pll_dyn_ctrl.sv
// Sequencer for the Gowin rPLL in dynamic-divider mode: reset, program codes, lock/settle, re-tune.
// Define PLL_DYN_CTRL_LOSS_CNT_EN to build the saturating lock-loss event counter.
module pll_dyn_ctrl #(
    parameter int         RST_CYCLES    = 16,
    parameter int         LOCK_TIMEOUT  = 65536,
    parameter int         SETTLE_CYCLES = 1024,
    parameter int         MAX_RETRY     = 3,
    parameter logic [5:0] DEF_IDSEL     = 6'h3B,
    parameter logic [5:0] DEF_FBDSEL    = 6'h3D,
    parameter logic [5:0] DEF_ODSEL     = 6'h30
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pll_lock,
    input  logic       i_req,
    input  logic [5:0] i_idsel,
    input  logic [5:0] i_fbdsel,
    input  logic [5:0] i_odsel,
    output logic       o_ack,
    output logic       o_busy,
    output logic       o_pll_reset,
    output logic [5:0] o_idsel,
    output logic [5:0] o_fbdsel,
    output logic [5:0] o_odsel,
    output logic       o_core_rst,
    output logic       o_locked,
    output logic       o_fail,
    output logic [7:0] o_loss_cnt
);

    localparam int MAX_AB    = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_COUNT = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
    localparam int TW        = ($clog2(MAX_COUNT) < 1) ? 1 : $clog2(MAX_COUNT);
    localparam int RW        = ($clog2(MAX_RETRY + 1) < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        PLLRST,
        WAITLOCK,
        SETTLE,
        RUN,
        FAIL
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [RW-1:0] retry;
    logic [RW-1:0] retry_inc;
    logic [1:0]    sync_q;
    logic          lock_s;
    logic          accept;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], i_pll_lock};
        end
    end

    assign lock_s    = sync_q[1];
    assign retry_inc = retry + RW'(1);
    // A request beats a simultaneous lock loss, so acceptance is decided before the state case.
    assign accept    = i_req && ((state == RUN) || (state == FAIL));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= PLLRST;
            timer       <= '0;
            retry       <= '0;
            o_ack       <= 1'b0;
            o_busy      <= 1'b1;
            o_pll_reset <= 1'b1;
            o_core_rst  <= 1'b1;
            o_locked    <= 1'b0;
            o_fail      <= 1'b0;
            o_idsel     <= DEF_IDSEL;
            o_fbdsel    <= DEF_FBDSEL;
            o_odsel     <= DEF_ODSEL;
`ifdef PLL_DYN_CTRL_LOSS_CNT_EN
            o_loss_cnt  <= 8'h00;
`endif
        end else begin
            o_ack <= 1'b0;
            if (accept) begin
                // New codes land on the same edge RESET rises so the PLL samples them while held.
                state       <= PLLRST;
                timer       <= '0;
                retry       <= '0;
                o_ack       <= 1'b1;
                o_busy      <= 1'b1;
                o_pll_reset <= 1'b1;
                o_core_rst  <= 1'b1;
                o_locked    <= 1'b0;
                o_fail      <= 1'b0;
                o_idsel     <= i_idsel;
                o_fbdsel    <= i_fbdsel;
                o_odsel     <= i_odsel;
            end else begin
                case (state)
                    PLLRST: begin
                        if (timer == RST_LAST) begin
                            state       <= WAITLOCK;
                            timer       <= '0;
                            o_pll_reset <= 1'b0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    WAITLOCK: begin
                        if (lock_s) begin
                            // The cycle that sees lock already counts toward the settle window.
                            state <= SETTLE;
                            timer <= TW'(1);
                        end else if (timer == LOCK_LAST) begin
                            retry <= retry_inc;
                            timer <= '0;
                            if (retry_inc < RETRY_LIMIT) begin
                                state       <= PLLRST;
                                o_pll_reset <= 1'b1;
                            end else begin
                                state  <= FAIL;
                                o_fail <= 1'b1;
                                o_busy <= 1'b0;
                            end
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    SETTLE: begin
                        if (!lock_s) begin
                            state <= WAITLOCK;
                            timer <= '0;
                        end else if (timer == SETTLE_LAST) begin
                            state      <= RUN;
                            timer      <= '0;
                            retry      <= '0;
                            o_core_rst <= 1'b0;
                            o_locked   <= 1'b1;
                            o_busy     <= 1'b0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    RUN: begin
                        if (!lock_s) begin
                            state      <= WAITLOCK;
                            timer      <= '0;
                            o_core_rst <= 1'b1;
                            o_locked   <= 1'b0;
                            o_busy     <= 1'b1;
`ifdef PLL_DYN_CTRL_LOSS_CNT_EN
                            if (o_loss_cnt != 8'hFF) begin
                                o_loss_cnt <= o_loss_cnt + 8'd1;
                            end
`endif
                        end
                    end
                    FAIL: begin
                        state <= FAIL;
                    end
                    default: begin
                        state       <= PLLRST;
                        timer       <= '0;
                        o_pll_reset <= 1'b1;
                        o_core_rst  <= 1'b1;
                        o_busy      <= 1'b1;
                        o_locked    <= 1'b0;
                        o_fail      <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifndef PLL_DYN_CTRL_LOSS_CNT_EN
    assign o_loss_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Self-checking bench for pll_dyn_ctrl: phase/deadline model compared every cycle plus hand-computed checks.
// Honours PLL_DYN_CTRL_LOSS_CNT_EN for the expected lock-loss count.
module tb_pll_dyn_ctrl;

    localparam int P_RST    = 4;
    localparam int P_TO     = 32;
    localparam int P_SET    = 8;
    localparam int P_RETRY  = 2;
`ifdef PLL_DYN_CTRL_LOSS_CNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       lock = 1'b0;
    logic       req = 1'b0;
    logic [5:0] idsel = 6'h00;
    logic [5:0] fbdsel = 6'h00;
    logic [5:0] odsel = 6'h00;
    logic       o_ack, o_busy, o_pll_reset, o_core_rst, o_locked, o_fail;
    logic [5:0] o_idsel, o_fbdsel, o_odsel;
    logic [7:0] o_loss_cnt;

    int checks = 0;
    int failures = 0;

    pll_dyn_ctrl #(
        .RST_CYCLES   (P_RST),
        .LOCK_TIMEOUT (P_TO),
        .SETTLE_CYCLES(P_SET),
        .MAX_RETRY    (P_RETRY)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_pll_lock (lock),
        .i_req      (req),
        .i_idsel    (idsel),
        .i_fbdsel   (fbdsel),
        .i_odsel    (odsel),
        .o_ack      (o_ack),
        .o_busy     (o_busy),
        .o_pll_reset(o_pll_reset),
        .o_idsel    (o_idsel),
        .o_fbdsel   (o_fbdsel),
        .o_odsel    (o_odsel),
        .o_core_rst (o_core_rst),
        .o_locked   (o_locked),
        .o_fail     (o_fail),
        .o_loss_cnt (o_loss_cnt)
    );

    initial forever #5 clk = ~clk;

    // Model: a phase plus absolute deadlines in edge numbers, a lock-streak length and a two-deep lock delay line.
    typedef enum int {PH_PULSE, PH_WAIT, PH_SETTLE, PH_RUN, PH_FAIL} phase_t;
    phase_t     m_ph;
    int         m_edge, m_deadline, m_attempts, m_streak, m_loss;
    bit         m_sync1, m_sync2, m_ack, model_valid = 1'b0;
    logic [5:0] m_id, m_fb, m_od;

    task automatic modelReset();
        m_ph = PH_PULSE; m_edge = 0; m_deadline = P_RST; m_attempts = 0; m_streak = 0;
        m_loss = 0; m_sync1 = 1'b0; m_sync2 = 1'b0; m_ack = 1'b0;
        m_id = 6'h3B; m_fb = 6'h3D; m_od = 6'h30; model_valid = 1'b1;
    endtask

    task automatic modelAccept();
        m_id = idsel; m_fb = fbdsel; m_od = odsel; m_ack = 1'b1; m_attempts = 0;
        m_ph = PH_PULSE; m_deadline = m_edge + P_RST;
    endtask

    task automatic modelStep();
        bit seen = m_sync2;
        m_ack = 1'b0;
        m_edge++;
        case (m_ph)
            PH_PULSE: if (m_edge == m_deadline) begin m_ph = PH_WAIT; m_deadline = m_edge + P_TO; end
            PH_WAIT: begin
                if (seen) begin
                    m_ph = PH_SETTLE; m_streak = 1;
                end else if (m_edge == m_deadline) begin
                    m_attempts++;
                    if (m_attempts < P_RETRY) begin m_ph = PH_PULSE; m_deadline = m_edge + P_RST; end
                    else m_ph = PH_FAIL;
                end
            end
            PH_SETTLE: begin
                if (!seen) begin
                    m_ph = PH_WAIT; m_deadline = m_edge + P_TO;
                end else begin
                    m_streak++;
                    if (m_streak == P_SET) begin m_ph = PH_RUN; m_attempts = 0; end
                end
            end
            PH_RUN: begin
                if (req) modelAccept();
                else if (!seen) begin
                    m_ph = PH_WAIT; m_deadline = m_edge + P_TO;
                    if (LOSS_EN && m_loss < 255) m_loss++;
                end
            end
            PH_FAIL: if (req) modelAccept();
            default: ;
        endcase
        m_sync2 = m_sync1;
        m_sync1 = lock;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) modelReset();
        else modelStep();
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic checkCycle();
        logic [31:0] act, want;
        if (!model_valid) return;
        act  = {o_pll_reset, o_core_rst, o_busy, o_locked, o_fail, o_ack,
                o_idsel, o_fbdsel, o_odsel, o_loss_cnt};
        want = {m_ph == PH_PULSE, m_ph != PH_RUN, (m_ph != PH_RUN) && (m_ph != PH_FAIL),
                m_ph == PH_RUN, m_ph == PH_FAIL, m_ack, m_id, m_fb, m_od, 8'(m_loss)};
        checks++;
        if (act !== want) begin
            failures++;
            $display("[TB] FAIL cycle_outputs edge=%0d: actual=%h required=%h", m_edge, act, want);
        end
    endtask

    // One clock edge: compare on the falling edge, then step past the next rising edge.
    task automatic tick();
        @(negedge clk);
        checkCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input bit l, input bit r, input logic [5:0] a, input logic [5:0] b,
                                 input logic [5:0] c);
        lock = l; req = r; idsel = a; fbdsel = b; odsel = c;
    endtask

    function automatic bit condNow(input int what);
        case (what)
            0: return o_pll_reset == 1'b0;
            1: return o_core_rst == 1'b0;
            2: return o_core_rst == 1'b1;
            3: return o_fail == 1'b1;
            default: return o_ack == 1'b1;
        endcase
    endfunction

    task automatic waitFor(input int what, input int limit, input string name, output int n);
        bit hit = 1'b0;
        n = 0;
        while (!hit && n < limit) begin
            tick();
            n++;
            hit = condNow(what);
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("[TB] FAIL %s: actual=timeout after %0d cycles required=event", name, limit);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_pll_reset"}, 32'(o_pll_reset), 32'd1);
        checkOutput({tag, "_core_rst"}, 32'(o_core_rst), 32'd1);
        checkOutput({tag, "_busy"}, 32'(o_busy), 32'd1);
        checkOutput({tag, "_locked_fail_ack"}, {29'd0, o_locked, o_fail, o_ack}, 32'd0);
        checkOutput({tag, "_sel"}, {14'd0, o_idsel, o_fbdsel, o_odsel}, {14'd0, 6'h3B, 6'h3D, 6'h30});
        checkOutput({tag, "_loss"}, 32'(o_loss_cnt), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, cnt;
        bit hit, prev_locked;

        #1 rst = 1'b1;
        #1 checkResetValues("reset");
        tick();
        tick();
        rst = 1'b0;

        // Power-up: PLL reports lock as soon as its RESET is released.
        waitFor(0, 20, "pwr_prst_end", n);
        checkOutput("pwr_prst_cycles", n, 4);
        applyStimulus(1, 0, 6'h00, 6'h00, 6'h00);
        waitFor(1, 40, "pwr_release", n);
        checkOutput("pwr_release_edges", n, 10);
        checkOutput("pwr_sel", {14'd0, o_idsel, o_fbdsel, o_odsel}, {14'd0, 6'h3B, 6'h3D, 6'h30});
        checkOutput("pwr_locked", 32'(o_locked), 32'd1);

        // Lock loss in RUN.
        lock = 1'b0;
        waitFor(2, 10, "loss_core_rst", n);
        checkOutput("loss_latency", n, 3);
        checkOutput("loss_count_1", 32'(o_loss_cnt), LOSS_EN ? 32'd1 : 32'd0);
        lock = 1'b1;
        waitFor(1, 40, "loss_relock", n);

        // Re-tune from RUN with 0A/0B/0C.
        checkOutput("retune_prst_before", 32'(o_pll_reset), 32'd0);
        applyStimulus(1, 1, 6'h0A, 6'h0B, 6'h0C);
        tick();
        checkOutput("retune_ack", 32'(o_ack), 32'd1);
        checkOutput("retune_sel", {14'd0, o_idsel, o_fbdsel, o_odsel}, {14'd0, 6'h0A, 6'h0B, 6'h0C});
        checkOutput("retune_prst_rise", 32'(o_pll_reset), 32'd1);
        req = 1'b0;
        tick();
        checkOutput("retune_ack_drop", 32'(o_ack), 32'd0);

        // Request raised during PLLRST and held: acknowledged only once RUN is reached.
        applyStimulus(1, 1, 6'h24, 6'h25, 6'h26);
        n = 0; hit = 1'b0; prev_locked = 1'b0;
        while (!hit && n < 40) begin
            prev_locked = o_locked;
            tick();
            n++;
            hit = o_ack;
        end
        checkOutput("held_req_delay", n, 12);
        checkOutput("held_req_prev_run", 32'(prev_locked), 32'd1);
        checkOutput("held_req_sel", {14'd0, o_idsel, o_fbdsel, o_odsel}, {14'd0, 6'h24, 6'h25, 6'h26});
        req = 1'b0;
        waitFor(1, 40, "held_relock", n);

        // Request and synchronized lock drop hit the same edge: the request wins.
        lock = 1'b0;
        tick();
        tick();
        applyStimulus(0, 1, 6'h11, 6'h12, 6'h13);
        tick();
        checkOutput("simul_ack", 32'(o_ack), 32'd1);
        checkOutput("simul_loss", 32'(o_loss_cnt), LOSS_EN ? 32'd1 : 32'd0);
        checkOutput("simul_sel", {14'd0, o_idsel, o_fbdsel, o_odsel}, {14'd0, 6'h11, 6'h12, 6'h13});
        applyStimulus(1, 0, 6'h11, 6'h12, 6'h13);
        waitFor(1, 40, "simul_relock", n);

        // Lock glitch while settling restarts the settle window.
        lock = 1'b0;
        waitFor(2, 10, "glitch_loss", n);
        lock = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        lock = 1'b0;
        tick();
        lock = 1'b1;
        waitFor(1, 40, "glitch_release", n);
        checkOutput("glitch_release_edges", n, 10);

        // Many lock losses: counter saturates.
        for (int k = 0; k < 300; k++) begin
            lock = 1'b0;
            waitFor(2, 10, "sat_drop", n);
            lock = 1'b1;
            waitFor(1, 40, "sat_relock", n);
        end
        checkOutput("sat_loss", 32'(o_loss_cnt), LOSS_EN ? 32'd255 : 32'd0);

        // Lock never asserts: two attempts, then FAIL.
        applyStimulus(0, 0, 6'h00, 6'h00, 6'h00);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n = 0; cnt = 0;
        while (!o_fail && n < 200) begin
            tick();
            n++;
            if (o_pll_reset) cnt++;
        end
        checkOutput("fail_edges", n, 72);
        checkOutput("fail_prst_cycles", cnt, 7);
        checkOutput("fail_flags", {28'd0, o_fail, o_busy, o_core_rst, o_pll_reset}, 32'b1010);
        for (int i = 0; i < 3; i++) tick();
        applyStimulus(0, 1, 6'h01, 6'h02, 6'h03);
        tick();
        checkOutput("fail_req_ack", 32'(o_ack), 32'd1);
        checkOutput("fail_req_sel", {14'd0, o_idsel, o_fbdsel, o_odsel}, {14'd0, 6'h01, 6'h02, 6'h03});
        checkOutput("fail_req_flags", {30'd0, o_fail, o_pll_reset}, 32'b01);

        // Asynchronous reset in the middle of SETTLE.
        applyStimulus(1, 0, 6'h01, 6'h02, 6'h03);
        for (int i = 0; i < 7; i++) tick();
        checkOutput("settle_state", {29'd0, o_busy, o_core_rst, o_locked}, 32'b110);
        #1 rst = 1'b1;
        #1 checkResetValues("async_reset");
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
